// File: rtl/store_write_buffer.sv
// Store write buffer: circular FIFO of word-aligned store writes that drains to the data memory port.
// It merges same-word stores into the newest entry and flags loads that overlap pending store bytes.
module store_write_buffer #(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Store_Valid,
   input  logic [ADDR_WIDTH-1:0]   Store_Addr,
   input  logic [31:0]             Store_Data,
   input  logic [3:0]              Store_Byte_En,
   output logic                    Store_Ready,
   input  logic                    Load_Valid,
   input  logic [ADDR_WIDTH-1:0]   Load_Addr,
   input  logic [3:0]              Load_Byte_En,
   output logic                    Load_Hazard,
   output logic                    Mem_Write_En,
   output logic [ADDR_WIDTH-1:0]   Mem_Write_Addr,
   output logic [31:0]             Mem_Write_Data,
   output logic [3:0]              Mem_Write_Strb,
   input  logic                    Mem_Write_Ready,
   output logic                    Buf_Empty,
   output logic [$clog2(DEPTH):0]  Buf_Count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = ADDR_WIDTH - 2;

   logic [TAG_W-1:0] tag_q  [DEPTH];
   logic [TAG_W-1:0] tag_d  [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [31:0]      data_d [DEPTH];
   logic [3:0]       strb_q [DEPTH];
   logic [3:0]       strb_d [DEPTH];

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [PTR_W-1:0] newest;
   logic [TAG_W-1:0] st_tag;
   logic [TAG_W-1:0] ld_tag;
   logic             buf_empty;
   logic             pop;
   logic             store_en;
   logic             coalesce_ok;
   logic             do_coal;
   logic             do_push;
   logic             hazard_any;
   logic [DEPTH-1:0] entry_valid;
   logic [3:0]       unused_addr_bits;

   assign unused_addr_bits = {Store_Addr[1:0], Load_Addr[1:0]};

   assign st_tag      = Store_Addr[ADDR_WIDTH-1:2];
   assign ld_tag      = Load_Addr[ADDR_WIDTH-1:2];
   assign newest      = tail_q - PTR_W'(1);
   assign buf_empty   = (count_q == '0);
   assign pop         = !buf_empty && Mem_Write_Ready;
   assign store_en    = Store_Valid && (Store_Byte_En != 4'b0000);

   // Merging into the newest entry is illegal only when it is also the head leaving this cycle.
   assign coalesce_ok = !buf_empty && (tag_q[newest] == st_tag)
                        && !((count_q == CNT_W'(1)) && pop);
   assign Store_Ready = coalesce_ok || (count_q < CNT_W'(DEPTH));
   assign do_coal     = store_en && coalesce_ok;
   assign do_push     = store_en && !coalesce_ok && (count_q < CNT_W'(DEPTH));

   assign Mem_Write_En   = !buf_empty;
   assign Mem_Write_Addr = buf_empty ? '0 : {tag_q[head_q], 2'b00};
   assign Mem_Write_Data = buf_empty ? '0 : data_q[head_q];
   assign Mem_Write_Strb = buf_empty ? '0 : strb_q[head_q];
   assign Buf_Empty      = buf_empty;
   assign Buf_Count      = count_q;

   // Slot i is live when its distance from the head (mod DEPTH) is below the count.
   always_comb begin
      logic [PTR_W-1:0] offs;
      entry_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offs           = PTR_W'(i) - head_q;
         entry_valid[i] = (CNT_W'(offs) < count_q);
      end
   end

   always_comb begin
      hazard_any = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entry_valid[i] && (tag_q[i] == ld_tag) && ((strb_q[i] & Load_Byte_En) != 4'b0000))
            hazard_any = 1'b1;
      end
   end

   assign Load_Hazard = Load_Valid && hazard_any;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      tag_d   = tag_q;
      data_d  = data_q;
      strb_d  = strb_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(pop);

      if (do_coal) begin
         for (int b = 0; b < 4; b++) begin
            if (Store_Byte_En[b])
               data_d[newest][b*8 +: 8] = Store_Data[b*8 +: 8];
         end
         strb_d[newest] = strb_q[newest] | Store_Byte_En;
      end

      if (do_push) begin
         tag_d[tail_q]  = st_tag;
         data_d[tail_q] = Store_Data;
         strb_d[tail_q] = Store_Byte_En;
         tail_d         = tail_q + PTR_W'(1);
      end

      if (pop)
         head_d = head_q + PTR_W'(1);
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++)
            strb_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         strb_q  <= strb_d;
      end
   end

   // NOTE: tag/data storage is deliberately not reset; liveness comes from the pointers and count.
   always_ff @(posedge Clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- Buffers formatted store writes (word-aligned data plus byte strobes from the store data formatter) between the execute/memory stage and the data memory write port.
- Decouples core stores from memory write latency.
- Merges back-to-back stores to the same word.
- Flags loads that overlap pending store bytes so the core can stall until those stores drain.

Parameters:
DEPTH, 4, number of buffered entries; power of 2, minimum 2
ADDR_WIDTH, 32, byte address width; the entry tag is bits [ADDR_WIDTH-1:2]

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Store_Valid  in  1  store request this cycle
Store_Addr  in  ADDR_WIDTH  store byte address; bits [1:0] ignored
Store_Data  in  32  lane-positioned store data (formatter output)
Store_Byte_En  in  4  byte strobes (formatter Write_Ctrl)
Store_Ready  out  1  store accepted when Store_Valid && Store_Ready
Load_Valid  in  1  load lookup this cycle
Load_Addr  in  ADDR_WIDTH  load byte address; bits [1:0] ignored
Load_Byte_En  in  4  bytes the load reads
Load_Hazard  out  1  load overlaps a pending store byte; core must stall
Mem_Write_En  out  1  head entry valid toward memory
Mem_Write_Addr  out  ADDR_WIDTH  head word address, bits [1:0] = 0
Mem_Write_Data  out  32  head data
Mem_Write_Strb  out  4  head byte strobes
Mem_Write_Ready  in  1  memory accepts head this cycle
Buf_Empty  out  1  no pending entries
Buf_Count  out  $clog2(DEPTH)+1  number of pending entries

Behaviour:
- Storage and pointers
  - Circular FIFO with head pointer, tail pointer and a registered count.
  - Each entry holds a word tag, 32-bit data and a 4-bit strobe.
- Reset
  - Reset is sampled on the Clk edge.
  - Clears head, tail and count, and zeroes all entry strobes.
  - After that edge: Mem_Write_En=0, Mem_Write_Addr/Data/Strb=0, Buf_Empty=1, Buf_Count=0, Load_Hazard=0, Store_Ready=1.
  - Reset mid-drain discards all pending stores.
- Drain side
  - Mem_Write_En = !Buf_Empty.
  - Mem_Write_Addr/Data/Strb are driven combinationally from the head entry, and are 0 when empty.
  - Pop occurs on Mem_Write_En && Mem_Write_Ready; the head advances and wraps modulo DEPTH.
  - Outputs hold stable while Mem_Write_Ready=0.
- Store accept (order of precedence)
  - Store_Byte_En==0: the request is a no-op and is never written. Store_Ready follows the normal rule.
  - Coalesce: applies when count>0, the tag matches the newest entry (tail-1), and that entry is not being popped this cycle (i.e. not count==1 with a pop).
    - Only the bytes whose Store_Byte_En bit is set are overwritten.
    - Strobe becomes the OR of old and new strobes; count is unchanged.
    - Store_Ready=1 even when full, so Store_Ready depends combinationally on Store_Addr.
  - Push: if not coalescing, Store_Ready = (count<DEPTH).
    - No same-cycle pass-through of a pop slot: a full buffer with a concurrent pop still deasserts Store_Ready.
    - Push writes the tail entry; the tail advances and wraps.
  - Push and pop in the same cycle leave count unchanged.
- Latency
  - A store accepted at edge N is visible on the Mem_Write_* outputs from cycle N+1.
  - A store into an empty buffer with Mem_Write_Ready=1 retires at edge N+1.
- Load hazard
  - Load_Hazard is combinational: Load_Valid AND, over all valid entries, (tag==Load_Addr tag) AND (strobe & Load_Byte_En)!=0.
  - The check is conservative: it includes the head entry even when it is being popped this cycle.
  - It ignores a store being accepted in the same cycle.
  - There is no data forwarding.
- Ordering
  - Memory sees entries in acceptance order.
  - Coalescing never reorders, because it only targets the newest entry.

Test Plan:
- Reset, then store Addr=0x100, Data=0x000000AB, Byte_En=0001 with Mem_Write_Ready=1 -> next cycle Mem_Write_En=1, Addr=0x100, Data=0x000000AB, Strb=0001; empty after the following edge.
- Mem_Write_Ready=0, push 4 stores to 0x0,0x4,0x8,0xC -> Buf_Count=4, Store_Ready=0 for a new address 0x10; a store to 0xC is still accepted (coalesced); drain order 0x0,0x4,0x8,0xC.
- Coalesce: with the newest entry at 0x20 holding Data=0x000000AB, Strb=0001 and Mem_Write_Ready=0, store 0x22 Data=0x12340000 Strb=1100 -> one entry, Data=0x123400AB, Strb=1101, Count=1.
- Load hazard: pending 0x40 Strb=0011; load 0x40 with Byte_En=1100 -> Load_Hazard=0; with Byte_En=0010 -> 1; load 0x44 -> 0.
- Simultaneous push and pop at Count=2 -> Count stays 2; pointers wrap correctly over 10 cycles of continuous traffic at DEPTH=4.
- Assert Reset while Count=3 and Mem_Write_Ready toggling -> after that edge Mem_Write_En=0, Buf_Empty=1, and the old entries never reach memory.
